siso_ctrl: RTL

SISO_CTRL -- requirements
Module: siso_ctrl

---
 rtl/siso_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/siso_ctrl.sv
// Parallel-in / serial-out frame controller with hold/pause and a one-cycle done pulse.
// Optional even-parity trailer bit is enabled by defining SISO_CTRL_PARITY_EN.
module siso_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             hold,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done,
    output logic [4:0]       bit_cnt
);

    // state | meaning
    // IDLE  | waiting for start; outputs quiet
    // SHIFT | current frame bit on sout with sout_valid
    // PAUSE | hold seen; last bit kept on sout, nothing advances
    // DONE  | one-cycle done pulse before returning to IDLE
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

`ifdef SISO_CTRL_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shifted;
    logic             load;
    logic             advance;
    logic             head;
    logic             frame_bit;
    logic             at_last;

    assign head         = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
    assign sreg_shifted = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
    assign at_last      = (bit_cnt == LAST_IDX);

`ifdef SISO_CTRL_PARITY_EN
    logic par;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par <= 1'b0;
        end else if (load) begin
            par <= ^din;
        end
    end

    // Data bits are exhausted once bit_cnt reaches WIDTH; the trailer is the stored parity.
    assign frame_bit = (bit_cnt == 5'(WIDTH)) ? par : head;
`else
    assign frame_bit = head;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A bit is consumed when leaving SHIFT or, if hold interrupted it, when leaving PAUSE.
    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        advance    = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sout       = frame_bit;
                sout_valid = 1'b1;
                if (hold) begin
                    state_nxt = PAUSE;
                end else begin
                    advance   = 1'b1;
                    state_nxt = at_last ? DONE : SHIFT;
                end
            end
            PAUSE: begin
                sout = frame_bit;
                if (!hold) begin
                    advance   = 1'b1;
                    state_nxt = at_last ? DONE : SHIFT;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg    <= '0;
            bit_cnt <= 5'd0;
        end else if (load) begin
            sreg    <= din;
            bit_cnt <= 5'd0;
        end else if (advance) begin
            sreg    <= sreg_shifted;
            bit_cnt <= at_last ? 5'd0 : bit_cnt + 5'd1;
        end
    end

endmodule
